// File: rtl/j1_io_interconnect.sv
// j1_io_interconnect
//   Registered, handshaken I/O fabric between a J1-class CPU I/O port and up
//   to NSLOTS memory-mapped peripherals, plus an internal status page.
//
//   Transaction flow: IDLE (decode) -> ACCESS (wait for slave) -> DONE (ack).
//   Status-page and unmapped accesses go straight from IDLE to DONE.
//
// Ports
//   sys_clk_i, sys_rst_i : clock (rising edge), asynchronous active-low reset
//   m_addr/m_rd/m_wr/m_wdata : master request, held until m_ack
//   m_rdata/m_ack/m_busy     : master response, one-cycle ack pulse, busy flag
//   s_cs/s_addr/s_wdata/s_rd/s_wr : registered slave-side strobes
//   s_rdata/s_ready          : packed slave read data, per-slave completion
//   err_irq                  : OR of the sticky error bits
module j1_io_interconnect #(
  parameter int                  NSLOTS      = 5,
  parameter int                  DW          = 16,
  parameter int                  SAW         = 8,
  parameter logic [NSLOTS*8-1:0] BASE_PAGES  = {8'h71, 8'h70, 8'h69, 8'h68, 8'h67},
  parameter logic [7:0]          STATUS_PAGE = 8'h7F,
  parameter logic [DW-1:0]       DEFAULT_RD  = 16'h0666,
  parameter int                  TIMEOUT     = 15
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [15:0]          m_addr,
  input  logic                 m_rd,
  input  logic                 m_wr,
  input  logic [DW-1:0]        m_wdata,
  output logic [DW-1:0]        m_rdata,
  output logic                 m_ack,
  output logic                 m_busy,
  output logic [NSLOTS-1:0]    s_cs,
  output logic [SAW-1:0]       s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic                 s_rd,
  output logic                 s_wr,
  input  logic [NSLOTS*DW-1:0] s_rdata,
  input  logic [NSLOTS-1:0]    s_ready,
  output logic                 err_irq
);

  localparam int             WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg;
  logic [15:0]         addr_reg;
  logic                is_wr_reg;
  logic [3:0]          slot_reg;
  logic [WCW-1:0]      wcnt_reg;
  logic                timeout_reg;
  logic                unmapped_reg;
  logic                conflict_reg;
  logic [3:0]          err_slot_reg;
  logic [15:0]         last_err_reg;
  logic [15:0]         acc_cnt_reg;
  logic [DW-1:0]       m_rdata_reg;
  logic                m_ack_reg;
  logic                m_busy_reg;
  logic [NSLOTS-1:0]   s_cs_reg;
  logic [SAW-1:0]      s_addr_reg;
  logic [DW-1:0]       s_wdata_reg;
  logic                s_rd_reg;
  logic                s_wr_reg;

  // ---------------------------------------------------------------------------
  // Page decode: one comparator per slot, lowest matching index wins.
  // ---------------------------------------------------------------------------
  logic [7:0]        page;
  logic [NSLOTS-1:0] page_match;
  logic              slot_hit;
  logic [3:0]        slot_idx;
  logic              status_hit;

  assign page       = m_addr[15:8];
  assign status_hit = (page == STATUS_PAGE);

  genvar gi;
  generate
    for (gi = 0; gi < NSLOTS; gi++) begin : g_page_cmp
      assign page_match[gi] = (page == BASE_PAGES[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    slot_hit = |page_match;
    slot_idx = 4'd0;
    // Scan downward so the lowest matching slot is the last one written.
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (page_match[i]) slot_idx = 4'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Selected-slave response mux, driven by the slot latched at IDLE.
  // ---------------------------------------------------------------------------
  logic          sel_ready;
  logic [DW-1:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (slot_reg == 4'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status page read mux and saturating access counter increment.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] status_rdata;
  logic [15:0]   cnt_inc;

  always_comb begin
    case (m_addr[1:0])
      2'd0:    status_rdata = DW'({8'b0, err_slot_reg, 1'b0, conflict_reg,
                                   unmapped_reg, timeout_reg});
      2'd1:    status_rdata = DW'(last_err_reg);
      2'd2:    status_rdata = DW'(acc_cnt_reg);
      default: status_rdata = '0;
    endcase
  end

  assign cnt_inc = (acc_cnt_reg == 16'hFFFF) ? acc_cnt_reg : acc_cnt_reg + 16'd1;

  // ---------------------------------------------------------------------------
  // Transaction FSM. Every state change into DONE raises m_ack and bumps the
  // access counter on the same edge, so a counter read reports prior acks.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      is_wr_reg    <= 1'b0;
      slot_reg     <= '0;
      wcnt_reg     <= '0;
      timeout_reg  <= 1'b0;
      unmapped_reg <= 1'b0;
      conflict_reg <= 1'b0;
      err_slot_reg <= '0;
      last_err_reg <= '0;
      acc_cnt_reg  <= '0;
      m_rdata_reg  <= '0;
      m_ack_reg    <= 1'b0;
      m_busy_reg   <= 1'b0;
      s_cs_reg     <= '0;
      s_addr_reg   <= '0;
      s_wdata_reg  <= '0;
      s_rd_reg     <= 1'b0;
      s_wr_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m_rd || m_wr) begin
            addr_reg   <= m_addr;
            is_wr_reg  <= m_wr;
            m_busy_reg <= 1'b1;
            // Simultaneous rd+wr proceeds as a write and is flagged.
            if (m_rd && m_wr) begin
              conflict_reg <= 1'b1;
              last_err_reg <= m_addr;
            end
            if (status_hit) begin
              state_reg   <= DONE;
              m_ack_reg   <= 1'b1;
              m_rdata_reg <= m_wr ? '0 : status_rdata;
              acc_cnt_reg <= cnt_inc;
              // Placed after the error update so a clear always wins.
              if (m_wr) begin
                case (m_addr[1:0])
                  2'd0: begin
                    timeout_reg  <= 1'b0;
                    unmapped_reg <= 1'b0;
                    conflict_reg <= 1'b0;
                    err_slot_reg <= '0;
                  end
                  2'd2:    acc_cnt_reg <= '0;
                  default: ;
                endcase
              end
            end else if (slot_hit) begin
              state_reg   <= ACCESS;
              slot_reg    <= slot_idx;
              wcnt_reg    <= '0;
              s_cs_reg    <= NSLOTS'(1) << slot_idx;
              s_addr_reg  <= m_addr[SAW-1:0];
              s_wdata_reg <= m_wdata;
              s_rd_reg    <= ~m_wr;
              s_wr_reg    <= m_wr;
            end else begin
              // Unmapped: writes are dropped, reads get the default word.
              state_reg    <= DONE;
              m_ack_reg    <= 1'b1;
              m_rdata_reg  <= m_wr ? '0 : DEFAULT_RD;
              acc_cnt_reg  <= cnt_inc;
              unmapped_reg <= 1'b1;
              last_err_reg <= m_addr;
            end
          end
        end

        ACCESS: begin
          if (sel_ready || (wcnt_reg == WLAST)) begin
            state_reg   <= DONE;
            m_ack_reg   <= 1'b1;
            acc_cnt_reg <= cnt_inc;
            s_cs_reg    <= '0;
            s_rd_reg    <= 1'b0;
            s_wr_reg    <= 1'b0;
            if (sel_ready) begin
              if (!is_wr_reg) m_rdata_reg <= sel_rdata;
            end else begin
              timeout_reg  <= 1'b1;
              err_slot_reg <= slot_reg;
              last_err_reg <= addr_reg;
              if (!is_wr_reg) m_rdata_reg <= DEFAULT_RD;
            end
          end else begin
            wcnt_reg <= wcnt_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg   <= IDLE;
          m_ack_reg   <= 1'b0;
          m_rdata_reg <= '0;
          m_busy_reg  <= 1'b0;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_rdata = m_rdata_reg;
  assign m_ack   = m_ack_reg;
  assign m_busy  = m_busy_reg;
  assign s_cs    = s_cs_reg;
  assign s_addr  = s_addr_reg;
  assign s_wdata = s_wdata_reg;
  assign s_rd    = s_rd_reg;
  assign s_wr    = s_wr_reg;
  assign err_irq = timeout_reg | unmapped_reg | conflict_reg;

endmodule
